// File: rtl/rc4_pkg.sv
// Shared RC4 key-schedule definitions: FSM state encoding and S-box size.
package rc4_pkg;

    localparam int S_SIZE = 256;

    typedef enum logic [3:0] {
        IDLE,
        INIT,
        RD_I,
        LD_I,
        RD_J,
        LD_J,
        WR_I,
        WR_J,
        DONE
    } rc4_state_e;

endpackage

// File: rtl/rc4_key_sel.sv
// Key byte mux and key-index successor; purely combinational, zero latency.
// No flow control: the caller decides when the index advances.
module rc4_key_sel #(
    parameter int MAX_KEY_BYTES = 3,
    parameter int KLW           = $clog2(MAX_KEY_BYTES + 1)
) (
    input  logic [8*MAX_KEY_BYTES-1:0] secret_key_i,
    input  logic [KLW-1:0]             kidx_i,
    input  logic [KLW-1:0]             klen_i,
    output logic [7:0]                 key_byte_o,
    output logic [KLW-1:0]             kidx_next_o
);

    // Byte 0 sits in the most significant position of the key bus.
    always_comb begin
        key_byte_o = '0;
        for (int k = 0; k < MAX_KEY_BYTES; k++) begin
            if (kidx_i == KLW'(k)) begin
                key_byte_o = secret_key_i[8*(MAX_KEY_BYTES-k)-1 -: 8];
            end
        end
    end

    // Compare-and-clear wrap instead of a modulo by the key length.
    assign kidx_next_o = (kidx_i == klen_i - KLW'(1)) ? '0 : kidx_i + KLW'(1);

endmodule

// File: rtl/rc4_ksa_engine.sv
// RC4 key-scheduling engine over an external 256x8 S-memory: 6 cycles per i, 1536 total (+256 if RC4_INIT_EN fills S).
// Start is accepted only when idle; requests while busy are dropped.
module rc4_ksa_engine
    import rc4_pkg::*;
#(
    parameter int MAX_KEY_BYTES = 3,
    parameter int KLW           = $clog2(MAX_KEY_BYTES + 1)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [KLW-1:0]             key_len,
    input  logic [8*MAX_KEY_BYTES-1:0] secret_key,
    input  logic [7:0]                 data_from_mem,
    output logic [7:0]                 address,
    output logic [7:0]                 data_to_mem,
    output logic                       wren,
    output logic                       busy,
    output logic                       done
);

    rc4_state_e     state_q, state_d;
    logic [8:0]     i_q, i_d;
    logic [7:0]     j_q, j_d;
    logic [7:0]     data_i_q, data_i_d;
    logic [7:0]     data_j_q, data_j_d;
    logic [KLW-1:0] kidx_q, kidx_d;
    logic [KLW-1:0] klen_q, klen_d;
    logic [KLW-1:0] klen_eff;
    logic [KLW-1:0] kidx_next;
    logic [7:0]     key_byte;

    assign klen_eff = (key_len == '0 || key_len > KLW'(MAX_KEY_BYTES))
                    ? KLW'(MAX_KEY_BYTES) : key_len;

    rc4_key_sel #(
        .MAX_KEY_BYTES (MAX_KEY_BYTES),
        .KLW           (KLW)
    ) u_key_sel (
        .secret_key_i (secret_key),
        .kidx_i       (kidx_q),
        .klen_i       (klen_q),
        .key_byte_o   (key_byte),
        .kidx_next_o  (kidx_next)
    );

    always_comb begin
        state_d     = state_q;
        i_d         = i_q;
        j_d         = j_q;
        data_i_d    = data_i_q;
        data_j_d    = data_j_q;
        kidx_d      = kidx_q;
        klen_d      = klen_q;
        address     = '0;
        data_to_mem = '0;
        wren        = 1'b0;
        busy        = (state_q != IDLE);
        done        = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    klen_d = klen_eff;
                    i_d    = '0;
                    j_d    = '0;
                    kidx_d = '0;
`ifdef RC4_INIT_EN
                    state_d = INIT;
`else
                    state_d = RD_I;
`endif
                end
            end
`ifdef RC4_INIT_EN
            // i doubles as the fill counter; it is back at 0 when the schedule starts.
            INIT: begin
                address     = i_q[7:0];
                data_to_mem = i_q[7:0];
                wren        = 1'b1;
                if (i_q == 9'(S_SIZE - 1)) begin
                    i_d     = '0;
                    state_d = RD_I;
                end else begin
                    i_d = i_q + 9'd1;
                end
            end
`endif
            RD_I: begin
                address = i_q[7:0];
                state_d = LD_I;
            end
            LD_I: begin
                address  = i_q[7:0];
                data_i_d = data_from_mem;
                j_d      = j_q + data_from_mem + key_byte;
                state_d  = RD_J;
            end
            RD_J: begin
                address = j_q;
                state_d = LD_J;
            end
            LD_J: begin
                address  = j_q;
                data_j_d = data_from_mem;
                state_d  = WR_I;
            end
            WR_I: begin
                address     = i_q[7:0];
                data_to_mem = data_j_q;
                wren        = 1'b1;
                state_d     = WR_J;
            end
            WR_J: begin
                address     = j_q;
                data_to_mem = data_i_q;
                wren        = 1'b1;
                i_d         = i_q + 9'd1;
                kidx_d      = kidx_next;
                state_d     = (i_q == 9'(S_SIZE - 1)) ? DONE : RD_I;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            i_q      <= '0;
            j_q      <= '0;
            data_i_q <= '0;
            data_j_q <= '0;
            kidx_q   <= '0;
            klen_q   <= '0;
        end else begin
            state_q  <= state_d;
            i_q      <= i_d;
            j_q      <= j_d;
            data_i_q <= data_i_d;
            data_j_q <= data_j_d;
            kidx_q   <= kidx_d;
            klen_q   <= klen_d;
        end
    end

endmodule

// File: tb/tb_rc4_ksa_engine.sv
// Bench for rc4_ksa_engine: software KSA reference, per-cycle write checker, directed key runs.
`timescale 1ns/1ps
module tb_rc4_ksa_engine;

    localparam int MKB = 8;
    localparam int KLW = $clog2(MKB + 1);
`ifdef RC4_INIT_EN
    localparam int       INIT_CYC  = 256;
    localparam bit [7:0] PRELOAD_X = 8'hA5;
`else
    localparam int       INIT_CYC  = 0;
    localparam bit [7:0] PRELOAD_X = 8'h00;
`endif
    localparam int RUN_CYC = INIT_CYC + 1536;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             start = 1'b0;
    logic [KLW-1:0]   key_len = '0;
    logic [8*MKB-1:0] secret_key = '0;
    logic [7:0]       data_from_mem;
    logic [7:0]       address;
    logic [7:0]       data_to_mem;
    logic             wren;
    logic             busy;
    logic             done;

    int tests = 0;
    int fails = 0;
    int wr_cnt = 0;
    int done_cnt = 0;

    always #5 clk = ~clk;

    rc4_ksa_engine #(.MAX_KEY_BYTES(MKB)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .key_len       (key_len),
        .secret_key    (secret_key),
        .data_from_mem (data_from_mem),
        .address       (address),
        .data_to_mem   (data_to_mem),
        .wren          (wren),
        .busy          (busy),
        .done          (done)
    );

    // S-memory: synchronous read, one-cycle latency.
    logic [7:0] mem [256];
    logic [7:0] rd_q;
    logic       preload = 1'b0;
    logic [7:0] preload_xor = 8'h00;

    always @(posedge clk) begin
        if (preload) begin
            for (int n = 0; n < 256; n++) mem[n] <= 8'(n) ^ preload_xor;
        end else if (wren === 1'b1) begin
            mem[address] <= data_to_mem;
        end
        rd_q <= mem[address];
    end
    assign data_from_mem = rd_q;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: plain software KSA producing the ordered list of memory writes.
    logic [7:0]  model_s [256];
    logic [15:0] exp_q [$];
    logic [15:0] dut_log [$];

    task automatic build_model(input logic [63:0] key, input int len);
        logic [7:0] s [256];
        logic [7:0] t;
        int jj;
        exp_q.delete();
        for (int n = 0; n < 256; n++) begin
            s[n] = 8'(n);
            if (INIT_CYC > 0) exp_q.push_back({8'(n), 8'(n)});
        end
        jj = 0;
        for (int ii = 0; ii < 256; ii++) begin
            jj = (jj + int'(s[ii]) + int'(key[63 - 8*(ii % len) -: 8])) % 256;
            exp_q.push_back({8'(ii), s[jj]});
            exp_q.push_back({8'(jj), s[ii]});
            t = s[ii]; s[ii] = s[jj]; s[jj] = t;
        end
        model_s = s;
    endtask

    logic [15:0] exp_w;
    always @(negedge clk) begin
        if (wren === 1'b1) begin
            wr_cnt++;
            dut_log.push_back({address, data_to_mem});
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_write: got addr %0d data %0d, expected no write", address, data_to_mem);
            end else begin
                exp_w = exp_q.pop_front();
                check("write_addr_data", {16'h0, address, data_to_mem}, {16'h0, exp_w});
            end
        end
        if (busy !== 1'b1) check("idle_outputs", {21'h0, wren, address, data_to_mem, done}, 32'h0);
        if (done === 1'b1) done_cnt++;
    end

    task automatic load_mem();
        preload_xor = PRELOAD_X;
        preload = 1'b1;
        @(posedge clk); #1;
        preload = 1'b0;
    endtask

    task automatic accept(input logic [63:0] key, input logic [KLW-1:0] klen);
        wr_cnt = 0;
        done_cnt = 0;
        dut_log.delete();
        secret_key = key;
        key_len = klen;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic run_ksa(input string tag, input logic [63:0] key, input logic [KLW-1:0] klen,
                           input int eff, input bit poke);
        int cyc;
        int mism;
        load_mem();
        build_model(key, eff);
        accept(key, klen);
        check({tag, "_busy_after_accept"}, busy, 1);
        cyc = 0;
        while (done !== 1'b1 && cyc < RUN_CYC + 50) begin
            @(posedge clk); #1;
            cyc++;
            if (poke) start = (cyc == 100);
        end
        start = 1'b0;
        check({tag, "_latency"}, cyc, RUN_CYC);
        check({tag, "_busy_at_done"}, busy, 1);
        @(posedge clk); #1;
        check({tag, "_done_one_cycle"}, done, 0);
        check({tag, "_busy_cleared"}, busy, 0);
        repeat (20) @(posedge clk);
        #1;
        check({tag, "_done_count"}, done_cnt, 1);
        check({tag, "_write_count"}, wr_cnt, INIT_CYC + 512);
        check({tag, "_writes_left"}, exp_q.size(), 0);
        mism = 0;
        for (int n = 0; n < 256; n++) if (mem[n] !== model_s[n]) mism++;
        check({tag, "_final_s_mismatches"}, mism, 0);
    endtask

    logic [15:0] lit_a [6];
    logic [15:0] lit_b [12];

    initial begin
        lit_a = '{16'h0000, 16'h0000, 16'h0101, 16'h0101, 16'h0203, 16'h0302};
        lit_b = '{16'h0001, 16'h0100, 16'h0103, 16'h0300, 16'h0208, 16'h0802,
                  16'h030C, 16'h0C00, 16'h0415, 16'h1504, 16'h051B, 16'h1B05};

        #1 rst_n = 1'b0;
        #1;
        check("reset_wren", wren, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_addr_data", {address, data_to_mem}, 0);
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;

        // Zero key, length 3: first swaps are (0,0), (1,1), (2,3).
        build_model(64'h0, 3);
        for (int k = 0; k < 6; k++) check("model_pin_a", exp_q[INIT_CYC + k], lit_a[k]);
        run_ksa("zero_key", 64'h0, 3, 3, 1'b0);
        for (int k = 0; k < 6; k++) check("dut_writes_a", dut_log[INIT_CYC + k], lit_a[k]);

        // Length 5 of an 8-byte key: i=5 must reuse key byte 0 (j=27).
        build_model(64'h0102030405060708, 5);
        for (int k = 0; k < 12; k++) check("model_pin_b", exp_q[INIT_CYC + k], lit_b[k]);
        run_ksa("len5", 64'h0102030405060708, 5, 5, 1'b0);
        for (int k = 0; k < 12; k++) check("dut_writes_b", dut_log[INIT_CYC + k], lit_b[k]);

        run_ksa("len0_poke", 64'h1122334455667788, 0, MKB, 1'b1);
        run_ksa("len_over", 64'hDEADBEEF01234567, 12, MKB, 1'b0);

        // Abort 700 cycles into a run, then a fresh run must complete.
        load_mem();
        build_model(64'hA0B1C2D3E4F50617, 4);
        accept(64'hA0B1C2D3E4F50617, 4);
        repeat (700) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("abort_wren", wren, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        @(posedge clk); #1;
        check("abort_held_wren", wren, 0);
        exp_q.delete();
        @(negedge clk) rst_n = 1'b1;

        run_ksa("key010203", 64'h0102030000000000, 3, 3, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
